// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller signal bundle: pipeline observations in, stall/flush controls and status out.
`timescale 1ns/1ps
interface pipeline_hazard_controller_if;
  logic [5:0]  Dopcode;
  logic [3:0]  Daddress1;
  logic [3:0]  Daddress2;
  logic [5:0]  Eopcode;
  logic [3:0]  Edest;
  logic        Emispredict;
  logic        Mbusy;
  logic        Fstall;
  logic        Dstall;
  logic        Dflush;
  logic        Eflush;
  logic        Estall;
  logic        Mstall;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  // Pipeline side: observes the stages and consumes the controls.
  modport master (
    output Dopcode, Daddress1, Daddress2, Eopcode, Edest, Emispredict, Mbusy,
    input  Fstall, Dstall, Dflush, Eflush, Estall, Mstall, state, stall_cycles, flush_count
  );

  // Controller side.
  modport slave (
    input  Dopcode, Daddress1, Daddress2, Eopcode, Edest, Emispredict, Mbusy,
    output Fstall, Dstall, Dflush, Eflush, Estall, Mstall, state, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, memory-wait holds,
// mispredict squashes, plus saturating stall/flush performance counters.
`timescale 1ns/1ps
module pipeline_hazard_controller #(
  parameter logic [5:0]  LOAD_OPCODE       = 6'b000100,
  parameter logic [5:0]  NOP_OPCODE        = 6'b000000,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1
) (
  input logic                         clk,
  input logic                         reset,
  pipeline_hazard_controller_if.slave bus
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StLdStall = 2'b01,
    StMemWait = 2'b10,
    StFlush   = 2'b11
  } state_e;

  // Remaining-cycle counts loaded when entering the multi-cycle states.
  localparam bit         LdMulti   = (LOAD_STALL_CYCLES > 1);
  localparam bit         FlushEn   = (FLUSH_CYCLES > 0);
  localparam logic [3:0] LdInit    = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [15:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  logic fstall, dstall, dflush, eflush, estall, mstall;
  logic flush_accept;
  logic hazard;

  assign hazard = (bus.Eopcode == LOAD_OPCODE) && (bus.Dopcode != NOP_OPCODE) &&
                  ((bus.Edest == bus.Daddress1) || (bus.Edest == bus.Daddress2));

  // Next-state and control decode; everything stays low while reset is held.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    fstall       = 1'b0;
    dstall       = 1'b0;
    dflush       = 1'b0;
    eflush       = 1'b0;
    estall       = 1'b0;
    mstall       = 1'b0;
    flush_accept = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StRun: begin
          if (bus.Mbusy) begin
            {fstall, dstall, estall, mstall} = 4'b1111;
            state_d = StMemWait;
          end else if (bus.Emispredict) begin
            dflush       = 1'b1;
            eflush       = 1'b1;
            flush_accept = 1'b1;
            if (FlushEn) begin
              state_d = StFlush;
              count_d = FlushInit;
            end
          end else if (hazard) begin
            {fstall, dstall, eflush} = 3'b111;
            if (LdMulti) begin
              state_d = StLdStall;
              count_d = LdInit;
            end
          end
        end
        StLdStall: begin
          // A memory hold abandons the bubble; the hazard is re-checked once back in RUN.
          if (bus.Mbusy) begin
            {fstall, dstall, estall, mstall} = 4'b1111;
            count_d = 4'd0;
            state_d = StMemWait;
          end else begin
            {fstall, dstall, eflush} = 3'b111;
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) state_d = StRun;
          end
        end
        StMemWait: begin
          if (bus.Mbusy) begin
            {fstall, dstall, estall, mstall} = 4'b1111;
          end else begin
            state_d = StRun;
          end
        end
        StFlush: begin
          // Memory hold freezes the flush countdown instead of cancelling it.
          if (bus.Mbusy) begin
            {fstall, dstall, estall, mstall} = 4'b1111;
          end else begin
            dflush  = 1'b1;
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State, countdown and saturating perf counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRun;
      count_q        <= 4'd0;
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (fstall && (stall_cycles_q != 16'hFFFF)) stall_cycles_q <= stall_cycles_q + 16'd1;
      if (flush_accept && (flush_count_q != 16'hFFFF)) flush_count_q <= flush_count_q + 16'd1;
    end
  end

  assign bus.Fstall       = fstall;
  assign bus.Dstall       = dstall;
  assign bus.Dflush       = dflush;
  assign bus.Eflush       = eflush;
  assign bus.Estall       = estall;
  assign bus.Mstall       = mstall;
  assign bus.state        = state_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: default-parameter instance driven from a vector table, plus a
// LOAD_STALL_CYCLES=3 / FLUSH_CYCLES=2 instance for the multi-cycle sequences.
`timescale 1ns/1ps
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] dop, eop;
  logic [3:0] a1, a2, ed;
  logic mis, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if if_a ();
  pipeline_hazard_controller_if if_b ();

  assign if_a.Dopcode = dop;   assign if_b.Dopcode = dop;
  assign if_a.Daddress1 = a1;  assign if_b.Daddress1 = a1;
  assign if_a.Daddress2 = a2;  assign if_b.Daddress2 = a2;
  assign if_a.Eopcode = eop;   assign if_b.Eopcode = eop;
  assign if_a.Edest = ed;      assign if_b.Edest = ed;
  assign if_a.Emispredict = mis; assign if_b.Emispredict = mis;
  assign if_a.Mbusy = busy;    assign if_b.Mbusy = busy;

  pipeline_hazard_controller u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  pipeline_hazard_controller #(
    .LOAD_STALL_CYCLES (3),
    .FLUSH_CYCLES      (2)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  // Control bits ordered {Fstall, Dstall, Dflush, Eflush, Estall, Mstall}.
  wire [5:0] ctrl_a = {if_a.Fstall, if_a.Dstall, if_a.Dflush, if_a.Eflush, if_a.Estall, if_a.Mstall};
  wire [5:0] ctrl_b = {if_b.Fstall, if_b.Dstall, if_b.Dflush, if_b.Eflush, if_b.Estall, if_b.Mstall};

  typedef struct {
    logic        rst;
    logic [5:0]  dop;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [5:0]  eop;
    logic [3:0]  ed;
    logic        mis;
    logic        busy;
    logic [5:0]  ctrl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] d_op, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [5:0] e_op, input logic [3:0] e_d,
                       input logic m, input logic b);
    reset = r; dop = d_op; a1 = s1; a2 = s2; eop = e_op; ed = e_d; mis = m; busy = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic m, input logic b);
    drive(1'b0, 6'h00, 4'd0, 4'd0, 6'h00, 4'd0, m, b);
  endtask

  task automatic hazard_in();
    drive(1'b0, 6'h01, 4'd3, 4'd0, 6'h04, 4'd3, 1'b0, 1'b0);
  endtask

  // Check the B instance's controls and state at the negedge, then advance one cycle.
  task automatic cyc_b(input string name, input logic [5:0] ectrl, input logic [1:0] est);
    @(negedge clk);
    chk(name, {32'd0, ctrl_b, if_b.state}, {32'd0, ectrl, est});
    tick();
  endtask

  task automatic do_reset();
    drive(1'b1, 6'h00, 4'd0, 4'd0, 6'h00, 4'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    drive(1'b1, 6'h00, 4'd0, 4'd0, 6'h00, 4'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    //            rst dop    a1 a2 eop    ed mis busy ctrl       st  sc  fc
    vq.push_back('{1, 6'h00, 0, 0, 6'h00, 0, 1, 1, 6'b000000, 0, 0, 0});
    vq.push_back('{0, 6'h01, 3, 0, 6'h04, 3, 0, 0, 6'b110100, 0, 0, 0});
    vq.push_back('{0, 6'h01, 3, 0, 6'h04, 5, 0, 0, 6'b000000, 0, 1, 0});
    vq.push_back('{0, 6'h00, 3, 0, 6'h04, 0, 0, 0, 6'b000000, 0, 1, 0});
    vq.push_back('{0, 6'h01, 3, 7, 6'h04, 7, 0, 0, 6'b110100, 0, 1, 0});
    vq.push_back('{0, 6'h01, 3, 7, 6'h05, 7, 0, 0, 6'b000000, 0, 2, 0});
    vq.push_back('{0, 6'h01, 3, 7, 6'h05, 7, 1, 0, 6'b001100, 0, 2, 0});
    vq.push_back('{0, 6'h00, 0, 0, 6'h00, 0, 0, 0, 6'b001000, 3, 2, 1});
    vq.push_back('{0, 6'h00, 0, 0, 6'h00, 0, 0, 0, 6'b000000, 0, 2, 1});
    vq.push_back('{0, 6'h01, 3, 0, 6'h04, 3, 1, 1, 6'b110011, 0, 2, 1});
    vq.push_back('{0, 6'h01, 3, 0, 6'h04, 3, 1, 1, 6'b110011, 2, 3, 1});
    vq.push_back('{0, 6'h01, 3, 0, 6'h04, 3, 1, 1, 6'b110011, 2, 4, 1});
    vq.push_back('{0, 6'h01, 3, 0, 6'h04, 3, 1, 1, 6'b110011, 2, 5, 1});
    vq.push_back('{0, 6'h01, 3, 0, 6'h04, 3, 1, 0, 6'b000000, 2, 6, 1});
    vq.push_back('{0, 6'h01, 3, 0, 6'h04, 3, 1, 0, 6'b001100, 0, 6, 1});
    vq.push_back('{0, 6'h01, 3, 0, 6'h04, 5, 0, 0, 6'b001000, 3, 6, 2});
    vq.push_back('{0, 6'h00, 0, 0, 6'h00, 0, 1, 0, 6'b001100, 0, 6, 2});
    vq.push_back('{0, 6'h00, 0, 0, 6'h00, 0, 0, 1, 6'b110011, 3, 6, 3});
    vq.push_back('{0, 6'h00, 0, 0, 6'h00, 0, 0, 1, 6'b110011, 3, 7, 3});
    vq.push_back('{0, 6'h00, 0, 0, 6'h00, 0, 0, 0, 6'b001000, 3, 8, 3});
    vq.push_back('{0, 6'h00, 0, 0, 6'h00, 0, 0, 0, 6'b000000, 0, 8, 3});

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].dop, vq[i].a1, vq[i].a2, vq[i].eop, vq[i].ed, vq[i].mis, vq[i].busy);
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {ctrl_a, if_a.state, if_a.stall_cycles, if_a.flush_count},
          {vq[i].ctrl, vq[i].st, vq[i].sc, vq[i].fc});
      tick();
    end

    // Three-cycle load-use bubble.
    do_reset();
    hazard_in();
    cyc_b("ld3_c0", 6'b110100, 2'b00);
    idle(1'b0, 1'b0);
    cyc_b("ld3_c1", 6'b110100, 2'b01);
    cyc_b("ld3_c2", 6'b110100, 2'b01);
    @(negedge clk);
    chk("ld3_stall_cycles", {24'd0, if_b.stall_cycles}, {24'd0, 16'd3});
    cyc_b("ld3_c3", 6'b000000, 2'b00);

    // Memory hold arriving in the middle of a load-use bubble.
    do_reset();
    hazard_in();
    cyc_b("ldbusy_c0", 6'b110100, 2'b00);
    idle(1'b0, 1'b1);
    cyc_b("ldbusy_c1", 6'b110011, 2'b01);
    idle(1'b0, 1'b0);
    cyc_b("ldbusy_c2", 6'b000000, 2'b10);
    cyc_b("ldbusy_c3", 6'b000000, 2'b00);
    @(negedge clk);
    chk("ldbusy_stall_cycles", {24'd0, if_b.stall_cycles}, {24'd0, 16'd2});

    // Two-cycle memory hold inside a two-cycle flush window.
    do_reset();
    idle(1'b1, 1'b0);
    cyc_b("flbusy_c0", 6'b001100, 2'b00);
    idle(1'b0, 1'b1);
    cyc_b("flbusy_c1", 6'b110011, 2'b11);
    cyc_b("flbusy_c2", 6'b110011, 2'b11);
    idle(1'b0, 1'b0);
    cyc_b("flbusy_c3", 6'b001000, 2'b11);
    cyc_b("flbusy_c4", 6'b001000, 2'b11);
    cyc_b("flbusy_c5", 6'b000000, 2'b00);
    @(negedge clk);
    chk("flbusy_flush_count", {24'd0, if_b.flush_count}, {24'd0, 16'd1});

    // Reset in the middle of a load-use bubble.
    do_reset();
    hazard_in();
    cyc_b("rst_c0", 6'b110100, 2'b00);
    idle(1'b0, 1'b0);
    @(negedge clk);
    chk("rst_in_ldstall", {32'd0, ctrl_b, if_b.state}, {32'd0, 6'b110100, 2'b01});
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_gates_ctrl", {34'd0, ctrl_b}, 40'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_after", {ctrl_b, if_b.state, if_b.stall_cycles, if_b.flush_count}, 40'd0);

    // Stall counter saturation via a long memory hold.
    do_reset();
    idle(1'b0, 1'b1);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat_fffe", {24'd0, if_a.stall_cycles}, {24'd0, 16'hFFFE});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_ffff", {22'd0, if_a.state, if_a.stall_cycles}, {22'd0, 2'b10, 16'hFFFF});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
